// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared constants and helpers for the instruction memory loader
package instr_mem_loader_pkg;

   // Loader FSM encodings; kept as plain vectors so they match legacy encodings bit for bit
   localparam logic [2:0] S_CNT_HI = 3'd0;
   localparam logic [2:0] S_CNT_LO = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   // Stream layout: 2 header bytes of word count, then 4 bytes per instruction word
   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   // Byte address of a word index; the index is zero-extended before scaling
   function automatic logic [31:0] word_addr(input logic [15:0] idx);
      return 32'(idx) * 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in, memory write port and status out
interface instr_mem_loader_if #(
   parameter int CNT_W = 16
);
   logic             inByte_valid_unused_guard;
   logic [7:0]       inByte;
   logic             inByteValid;
   logic             inReload;
   logic             outWrEn;
   logic [31:0]      outWrAddr;
   logic [31:0]      outWrData;
   logic             outCpuHold;
   logic             outDone;
   logic             outError;
   logic [CNT_W-1:0] outWordsLoaded;

   // Loader side: consumes the byte stream, drives the memory write port and status
   modport slave (
      input  inByte, inByteValid, inReload,
      output outWrEn, outWrAddr, outWrData, outCpuHold, outDone, outError, outWordsLoaded
   );

   // Source side: byte producer plus the consumer of the write port and status
   modport master (
      output inByte, inByteValid, inReload,
      input  outWrEn, outWrAddr, outWrData, outCpuHold, outDone, outError, outWordsLoaded
   );
endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// rtl/instr_mem_loader_byte_assembler.sv - packs big-endian bytes into 32-bit words
module instr_mem_loader_byte_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        word_ready,
   output logic [31:0] word
);

   // Only the first three bytes of a word need storing; the fourth is used as it arrives
   logic [23:0] shift;
   logic [1:0]  idx;

   // Ready and word are combinational so the caller can register them into a one-cycle pulse
   assign word_ready = byte_valid && (idx == 2'd3);
   assign word       = {shift, byte_in};

   // Shift in MSB-first bytes; clear drops any partial word on reset or reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift <= '0;
         idx   <= '0;
      end else if (clear) begin
         shift <= '0;
         idx   <= '0;
      end else if (byte_valid) begin
         shift <= {shift[15:0], byte_in};
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a counted byte stream into instruction memory and holds the CPU
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic reset,
   instr_mem_loader_if.slave bus
);

   logic [2:0]       state;
   logic [7:0]       cnt_hi;
   logic [CNT_W-1:0] word_count;
   logic [CNT_W-1:0] words;
   logic [CNT_W-1:0] hdr_count;
   logic             wr_en;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   logic             hold;
   logic             done;
   logic             error;

   logic             asm_valid;
   logic             asm_clear;
   logic             asm_ready;
   logic [31:0]      asm_word;

   assign hdr_count = CNT_W'({cnt_hi, bus.inByte});

   // The assembler only runs in S_DATA; once all N words are counted, trailing bytes are dropped
   assign asm_clear = (state != S_DATA);
   assign asm_valid = bus.inByteValid && (state == S_DATA) && (words != word_count);

   instr_mem_loader_byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_in    (bus.inByte),
      .byte_valid (asm_valid),
      .word_ready (asm_ready),
      .word       (asm_word)
   );

   assign bus.outWrEn        = wr_en;
   assign bus.outWrAddr      = wr_addr;
   assign bus.outWrData      = wr_data;
   assign bus.outCpuHold     = hold;
   assign bus.outDone        = done;
   assign bus.outError       = error;
   assign bus.outWordsLoaded = words;

   // Header parse, write pulse generation, word counting and done/error status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_CNT_HI;
         cnt_hi     <= '0;
         word_count <= '0;
         words      <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         hold       <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_CNT_HI: begin
               if (bus.inByteValid) begin
                  cnt_hi <= bus.inByte;
                  state  <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (bus.inByteValid) begin
                  word_count <= hdr_count;
                  if (hdr_count == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     hold  <= 1'b0;
                  end else if (hdr_count > CNT_W'(MEM_DEPTH)) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // The pulse is registered here, so the count advances in the pulse cycle itself
               if (asm_ready) begin
                  wr_en   <= 1'b1;
                  wr_data <= asm_word;
                  wr_addr <= word_addr(16'(words));
                  words   <= words + CNT_W'(1);
               end
               // Finish one cycle after the last pulse, when the count has reached N
               if (wr_en && (words == word_count)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  hold  <= 1'b0;
               end
            end
            S_DONE, S_ERROR: begin
               if (bus.inReload) begin
                  state <= S_CNT_HI;
                  hold  <= 1'b1;
                  done  <= 1'b0;
                  error <= 1'b0;
                  words <= '0;
               end
            end
            default: state <= S_CNT_HI;
         endcase
      end
   end

endmodule
